// File: rtl/counter_rw_port.sv
// CPU-side read/write port for one 8254 counter channel: control word decode,
// byte-sequenced initial count writes with a load pulse, and latched/live count reads.
module counter_rw_port #(
   parameter int         DATA_W = 8,
   parameter logic [1:0] RST_RW = 2'b11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  ctrl_wr,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [DATA_W-1:0]     data_in,
   output logic [DATA_W-1:0]     data_out,
   input  logic [2*DATA_W-1:0]   current_count,
   output logic [2*DATA_W-1:0]   count_reg,
   output logic                  count_load,
   output logic [2:0]            mode,
   output logic                  bcd,
   output logic                  null_count
);

   typedef enum logic [1:0] {
      RW_LATCH = 2'b00,
      RW_LSB   = 2'b01,
      RW_MSB   = 2'b10,
      RW_WORD  = 2'b11
   } rw_e;

   typedef enum logic {
      BYTE_LSB = 1'b0,
      BYTE_MSB = 1'b1
   } byte_e;

   rw_e                 rw_fmt;
   byte_e               wr_toggle;
   byte_e               rd_toggle;
   logic                latched;
   logic [2*DATA_W-1:0] latch_reg;

   rw_e                 cw_rw;
   logic                do_ctrl;
   logic                do_wr;
   logic                do_rd;
   logic                do_format;
   logic                do_latch;
   logic [2*DATA_W-1:0] read_src;
   logic [DATA_W-1:0]   read_lo;
   logic [DATA_W-1:0]   read_hi;

   // One strobe wins per cycle: control word, then write, then read.
   always_comb begin
      cw_rw     = rw_e'(data_in[5:4]);
      do_ctrl   = cs && ctrl_wr;
      do_wr     = cs && wr && !ctrl_wr;
      do_rd     = cs && rd && !ctrl_wr && !wr;
      do_format = do_ctrl && (cw_rw != RW_LATCH);
      do_latch  = do_ctrl && (cw_rw == RW_LATCH);
      read_src  = latched ? latch_reg : current_count;
      read_lo   = read_src[DATA_W-1:0];
      read_hi   = read_src[2*DATA_W-1:DATA_W];
   end

   // Control word fields; a latch command leaves them untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_fmt <= rw_e'(RST_RW);
         mode   <= 3'd0;
         bcd    <= 1'b0;
      end else if (do_format) begin
         rw_fmt <= cw_rw;
         mode   <= data_in[3:1];
         bcd    <= data_in[0];
      end
   end

   // Count write sequencing; count_load is a registered one-cycle pulse after the completing byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg  <= '0;
         wr_toggle  <= BYTE_LSB;
         count_load <= 1'b0;
         null_count <= 1'b1;
      end else begin
         count_load <= 1'b0;
         if (do_format) begin
            wr_toggle  <= BYTE_LSB;
            null_count <= 1'b1;
         end else if (do_wr) begin
            case (rw_fmt)
               RW_LSB: begin
                  count_reg  <= {{DATA_W{1'b0}}, data_in};
                  count_load <= 1'b1;
                  null_count <= 1'b0;
               end
               RW_MSB: begin
                  count_reg  <= {data_in, {DATA_W{1'b0}}};
                  count_load <= 1'b1;
                  null_count <= 1'b0;
               end
               RW_WORD: begin
                  if (wr_toggle == BYTE_LSB) begin
                     count_reg[DATA_W-1:0] <= data_in;
                     wr_toggle             <= BYTE_MSB;
                     null_count            <= 1'b1;
                  end else begin
                     count_reg[2*DATA_W-1:DATA_W] <= data_in;
                     wr_toggle                    <= BYTE_LSB;
                     count_load                   <= 1'b1;
                     null_count                   <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Read path: the first latch command holds until the read sequence that consumes it completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out  <= '0;
         rd_toggle <= BYTE_LSB;
         latched   <= 1'b0;
         latch_reg <= '0;
      end else if (do_format) begin
         rd_toggle <= BYTE_LSB;
         latched   <= 1'b0;
      end else if (do_latch) begin
         if (!latched) begin
            latch_reg <= current_count;
            latched   <= 1'b1;
         end
      end else if (do_rd) begin
         case (rw_fmt)
            RW_LSB: begin
               data_out <= read_lo;
               latched  <= 1'b0;
            end
            RW_MSB: begin
               data_out <= read_hi;
               latched  <= 1'b0;
            end
            RW_WORD: begin
               if (rd_toggle == BYTE_LSB) begin
                  data_out  <= read_lo;
                  rd_toggle <= BYTE_MSB;
               end else begin
                  data_out  <= read_hi;
                  rd_toggle <= BYTE_LSB;
                  latched   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_rw_port.sv
// Randomized and directed bench for counter_rw_port with a queue-based scoreboard
// fed by a behavioural model and drained by a negedge monitor.
module tb_counter_rw_port;

   logic        clk;
   logic        rst_n;
   logic        cs;
   logic        ctrl_wr;
   logic        wr;
   logic        rd;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [15:0] current_count;
   logic [15:0] count_reg;
   logic        count_load;
   logic [2:0]  mode;
   logic        bcd;
   logic        null_count;

   counter_rw_port #(.DATA_W(8), .RST_RW(2'b11)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cs(cs),
      .ctrl_wr(ctrl_wr),
      .wr(wr),
      .rd(rd),
      .data_in(data_in),
      .data_out(data_out),
      .current_count(current_count),
      .count_reg(count_reg),
      .count_load(count_load),
      .mode(mode),
      .bcd(bcd),
      .null_count(null_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      int          due;
   } exp_t;

   exp_t loadQ[$];
   exp_t readQ[$];

   int checks = 0;
   int passed = 0;
   int ncyc   = 0;

   // Reference model state, expressed directly in terms of the 8254 programming rules.
   logic [1:0]  m_fmt;
   logic [2:0]  m_mode;
   logic        m_bcd;
   logic [15:0] m_cnt;
   int          m_wbyte;
   int          m_rbyte;
   logic        m_latched;
   logic [15:0] m_latch;
   logic        m_null;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic failNote(input string name, input logic [15:0] actual);
      checks++;
      $display("[TB] FAIL %s: got %h at cycle %0d (t=%0t)", name, actual, ncyc, $time);
   endtask

   task automatic modelReset();
      m_fmt = 2'b11; m_mode = 3'd0; m_bcd = 1'b0; m_cnt = 16'h0000;
      m_wbyte = 0; m_rbyte = 0; m_latched = 1'b0; m_latch = 16'h0000; m_null = 1'b1;
      loadQ.delete();
      readQ.delete();
   endtask

   task automatic pushLoad();
      exp_t e;
      e.val = m_cnt; e.due = ncyc + 2;
      loadQ.push_back(e);
      m_null = 1'b0;
   endtask

   task automatic pushRead(input logic [7:0] b);
      exp_t e;
      e.val = {8'h00, b}; e.due = ncyc + 2;
      readQ.push_back(e);
   endtask

   task automatic modelApply(input logic c, input logic cw, input logic w, input logic r, input logic [7:0] d);
      logic [15:0] src;
      if (!c) return;
      if (cw) begin
         if (d[5:4] != 2'b00) begin
            m_fmt = d[5:4]; m_mode = d[3:1]; m_bcd = d[0];
            m_wbyte = 0; m_rbyte = 0; m_latched = 1'b0; m_null = 1'b1;
         end else if (!m_latched) begin
            m_latched = 1'b1; m_latch = current_count;
         end
      end else if (w) begin
         if (m_fmt == 2'b01) begin
            m_cnt = {8'h00, d}; pushLoad();
         end else if (m_fmt == 2'b10) begin
            m_cnt = {d, 8'h00}; pushLoad();
         end else if (m_wbyte == 0) begin
            m_cnt = {m_cnt[15:8], d}; m_wbyte = 1; m_null = 1'b1;
         end else begin
            m_cnt = {d, m_cnt[7:0]}; m_wbyte = 0; pushLoad();
         end
      end else if (r) begin
         src = m_latched ? m_latch : current_count;
         if (m_fmt == 2'b01) begin
            pushRead(src[7:0]); m_latched = 1'b0;
         end else if (m_fmt == 2'b10) begin
            pushRead(src[15:8]); m_latched = 1'b0;
         end else if (m_rbyte == 0) begin
            pushRead(src[7:0]); m_rbyte = 1;
         end else begin
            pushRead(src[15:8]); m_rbyte = 0; m_latched = 1'b0;
         end
      end
   endtask

   // Drives one strobe cycle starting just after a posedge and returns just after the sampling edge.
   task automatic applyStimulus(input logic c, input logic cw, input logic w, input logic r, input logic [7:0] d);
      cs = c; ctrl_wr = cw; wr = w; rd = r; data_in = d;
      modelApply(c, cw, w, r, d);
      @(posedge clk); #1;
      cs = 1'b0; ctrl_wr = 1'b0; wr = 1'b0; rd = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_mode"}, {13'd0, mode}, {13'd0, m_mode});
      checkOutput({tag, "_bcd"}, {15'd0, bcd}, {15'd0, m_bcd});
      checkOutput({tag, "_count_reg"}, count_reg, m_cnt);
      checkOutput({tag, "_null_count"}, {15'd0, null_count}, {15'd0, m_null});
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      cs = 1'b0; ctrl_wr = 1'b0; wr = 1'b0; rd = 1'b0;
      modelReset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Monitor: pops expected loads/reads when their due cycle arrives.
   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (count_load) begin
         if (loadQ.size() == 0 || loadQ[0].due != ncyc) failNote("count_load_unexpected", count_reg);
         else begin
            e = loadQ.pop_front();
            checkOutput("count_load_value", count_reg, e.val);
         end
      end else if (loadQ.size() > 0 && loadQ[0].due <= ncyc) begin
         e = loadQ.pop_front();
         failNote("count_load_missing", e.val);
      end
      if (readQ.size() > 0 && readQ[0].due <= ncyc) begin
         e = readQ.pop_front();
         if (e.due == ncyc) checkOutput("read_data", {8'h00, data_out}, e.val);
         else failNote("read_stale", e.val);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] d;
      int         op;
      logic       c;
      current_count = 16'h0000;
      data_in = 8'h00;
      cs = 1'b0; ctrl_wr = 1'b0; wr = 1'b0; rd = 1'b0;
      rst_n = 1'b0;
      modelReset();
      #12;
      checkOutput("reset_data_out", {8'h00, data_out}, 16'h0000);
      checkOutput("reset_count_load", {15'd0, count_load}, 16'h0000);
      checkOutput("reset_null_count", {15'd0, null_count}, 16'h0001);
      checkOutput("reset_count_reg", count_reg, 16'h0000);
      checkOutput("reset_mode", {13'd0, mode}, 16'h0000);
      checkOutput("reset_bcd", {15'd0, bcd}, 16'h0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] word write LSB then MSB");
      applyStimulus(1, 1, 0, 0, 8'h32);
      applyStimulus(1, 0, 1, 0, 8'h34);
      idleCycles(1);
      checkOutput("t2_null_after_lsb", {15'd0, null_count}, 16'h0001);
      applyStimulus(1, 0, 1, 0, 8'h12);
      idleCycles(2);
      checkOutput("t2_count_reg", count_reg, 16'h1234);
      checkOutput("t2_mode", {13'd0, mode}, 16'h0001);
      checkOutput("t2_null_after_load", {15'd0, null_count}, 16'h0000);

      $display("[TB] single-byte formats");
      applyStimulus(1, 1, 0, 0, 8'h10);
      applyStimulus(1, 0, 1, 0, 8'hA5);
      idleCycles(2);
      checkOutput("t3_lsb_only", count_reg, 16'h00A5);
      applyStimulus(1, 1, 0, 0, 8'h20);
      applyStimulus(1, 0, 1, 0, 8'h5A);
      idleCycles(2);
      checkOutput("t3_msb_only", count_reg, 16'h5A00);

      $display("[TB] counter latch holds first value");
      applyStimulus(1, 1, 0, 0, 8'h30);
      current_count = 16'hBEEF;
      applyStimulus(1, 1, 0, 0, 8'h00);
      current_count = 16'h0001;
      applyStimulus(1, 1, 0, 0, 8'h00);
      applyStimulus(1, 0, 0, 1, 8'h00);
      idleCycles(1);
      checkOutput("t4_latched_lsb", {8'h00, data_out}, 16'h00EF);
      applyStimulus(1, 0, 0, 1, 8'h00);
      idleCycles(1);
      checkOutput("t4_latched_msb", {8'h00, data_out}, 16'h00BE);
      applyStimulus(1, 0, 0, 1, 8'h00);
      idleCycles(1);
      checkOutput("t4_live_lsb", {8'h00, data_out}, 16'h0001);
      applyStimulus(1, 0, 0, 1, 8'h00);

      $display("[TB] control word beats write in same cycle");
      applyStimulus(1, 1, 1, 0, 8'h36);
      idleCycles(2);
      checkOutput("t5_mode", {13'd0, mode}, 16'h0003);
      checkOutput("t5_null", {15'd0, null_count}, 16'h0001);
      applyStimulus(1, 0, 1, 0, 8'h11);
      applyStimulus(1, 0, 1, 0, 8'h22);
      idleCycles(2);
      checkOutput("t5_count_reg", count_reg, 16'h2211);

      $display("[TB] reset abandons partial write");
      applyStimulus(1, 1, 0, 0, 8'h32);
      applyStimulus(1, 0, 1, 0, 8'h34);
      doReset();
      applyStimulus(1, 0, 1, 0, 8'h12);
      idleCycles(3);
      checkOutput("t6_count_reg", count_reg, 16'h0012);
      checkOutput("t6_null", {15'd0, null_count}, 16'h0001);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) current_count = 16'($urandom);
         d  = 8'($urandom);
         c  = ($urandom_range(0, 9) != 0);
         op = $urandom_range(0, 9);
         if (op <= 1) begin
            if ($urandom_range(0, 2) == 0) d[5:4] = 2'b00;
            applyStimulus(c, 1, 0, 0, d);
         end else if (op == 2) applyStimulus(c, 1, 1, 0, d);
         else if (op == 3) applyStimulus(c, 0, 1, 1, d);
         else if (op <= 6) applyStimulus(c, 0, 1, 0, d);
         else applyStimulus(c, 0, 0, 1, d);
         idleCycles(1);
         checkState("rand");
         if ($urandom_range(0, 99) == 0) begin
            idleCycles(2);
            doReset();
         end
      end

      idleCycles(4);
      checkOutput("load_queue_drained", 16'(loadQ.size()), 16'h0000);
      checkOutput("read_queue_drained", 16'(readQ.size()), 16'h0000);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
